// File: rtl/compare.sv
// Registered 32-bit unsigned comparator: equality, sorted pair, and MS/LS differing nibble indices.
// Latency: one cycle from A/B sampled at the rising edge of clk to EN/W1/W2/D1/D2.
// Backpressure: none; recomputes on every edge with no enable or handshake.
//
// Ports:
//   clk    system clock, rising-edge
//   rst_n  asynchronous active-low reset, clears all outputs
//   A, B   32-bit unsigned operands
//   EN     1 when A == B
//   W1     index of the most significant differing nibble (0 when equal)
//   W2     index of the least significant differing nibble (0 when equal)
//   D1     max(A, B)
//   D2     min(A, B)
module compare (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        EN,
    output logic [2:0]  W1,
    output logic [2:0]  W2,
    output logic [31:0] D1,
    output logic [31:0] D2
);

    logic [7:0]  w_diff;
    logic [2:0]  w_msn;
    logic [2:0]  w_lsn;
    logic        w_a_ge_b;

    logic        r_en;
    logic [2:0]  r_w1;
    logic [2:0]  r_w2;
    logic [31:0] r_d1;
    logic [31:0] r_d2;

    always_comb begin
        w_diff = '0;
        for (int i = 0; i < 8; i++) begin
            w_diff[i] = (A[4*i +: 4] != B[4*i +: 4]);
        end
    end

    // Scanning upward lets the last hit win, giving the highest set bit.
    always_comb begin
        w_msn = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_diff[i]) begin
                w_msn = 3'(i);
            end
        end
    end

    // Scanning downward lets the last hit win, giving the lowest set bit.
    always_comb begin
        w_lsn = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_lsn = 3'(i);
            end
        end
    end

    assign w_a_ge_b = (A >= B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= 1'b0;
            r_w1 <= 3'd0;
            r_w2 <= 3'd0;
            r_d1 <= 32'd0;
            r_d2 <= 32'd0;
        end else begin
            r_en <= (w_diff == 8'd0);
            r_w1 <= w_msn;
            r_w2 <= w_lsn;
            r_d1 <= w_a_ge_b ? A : B;
            r_d2 <= w_a_ge_b ? B : A;
        end
    end

    assign EN = r_en;
    assign W1 = r_w1;
    assign W2 = r_w2;
    assign D1 = r_d1;
    assign D2 = r_d2;

endmodule

// File: tb/tb_compare.sv
module tb_compare;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        EN;
    logic [2:0]  W1;
    logic [2:0]  W2;
    logic [31:0] D1;
    logic [31:0] D2;

    int checks = 0;
    int errors = 0;

    compare dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .EN   (EN),
        .W1   (W1),
        .W2   (W2),
        .D1   (D1),
        .D2   (D2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the outputs are a pure function of the operand pair last
    // sampled at a rising edge with reset high; with no such sample, all zero.
    bit          have_sample = 1'b0;
    logic [31:0] s_a, s_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_sample = 1'b0;
        end else begin
            have_sample = 1'b1;
            s_a = A;
            s_b = B;
        end
    end

    // Nibble positions derived from the bit positions of A^B: the highest and
    // lowest set bits, divided by four.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic en, output logic [2:0] w1, output logic [2:0] w2,
                         output logic [31:0] d1, output logic [31:0] d2);
        logic [31:0] x;
        int hi, lo;
        x  = a ^ b;
        hi = -1;
        lo = -1;
        for (int k = 0; k < 32; k++) begin
            if (x[k]) begin
                hi = k;
                if (lo < 0) lo = k;
            end
        end
        en = (a == b);
        w1 = (hi < 0) ? 3'd0 : 3'(hi / 4);
        w2 = (lo < 0) ? 3'd0 : 3'(lo / 4);
        if (a > b) begin
            d1 = a; d2 = b;
        end else begin
            d1 = b; d2 = a;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic en, input logic [2:0] w1,
                           input logic [2:0] w2, input logic [31:0] d1, input logic [31:0] d2);
        chk({tag, ".EN"}, {31'd0, EN}, {31'd0, en});
        chk({tag, ".W1"}, {29'd0, W1}, {29'd0, w1});
        chk({tag, ".W2"}, {29'd0, W2}, {29'd0, w2});
        chk({tag, ".D1"}, D1, d1);
        chk({tag, ".D2"}, D2, d2);
    endtask

    // Continuous check away from the active edge.
    always @(negedge clk) begin
        logic        en;
        logic [2:0]  w1, w2;
        logic [31:0] d1, d2;
        if (have_sample) begin
            model(s_a, s_b, en, w1, w2, d1, d2);
            chk_all("model", en, w1, w2, d1, d2);
            chk("inv.D1geD2", {31'd0, (D1 >= D2)}, 32'd1);
            chk("inv.W1geW2", {31'd0, (W1 >= W2)}, 32'd1);
            if (EN) chk("inv.EN_D", D1 ^ D2, 32'd0);
        end else begin
            chk_all("reset", 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);
        end
    end

    // Drive just after a falling edge, then look 1 time unit after the rising edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        A = 32'd5;
        B = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        chk_all("lit.in_reset", 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("lit.release", 1'b0, 3'd0, 3'd0, 32'd5, 32'd3);

        apply(32'h4, 32'h2);
        chk_all("lit.unequal", 1'b0, 3'd0, 3'd0, 32'h4, 32'h2);
        apply(32'h4, 32'h4);
        chk_all("lit.equal", 1'b1, 3'd0, 3'd0, 32'h4, 32'h4);
        apply(32'h0000_1000, 32'h1000_0001);
        chk_all("lit.swap", 1'b0, 3'd7, 3'd0, 32'h1000_0001, 32'h0000_1000);
        apply(32'h00F0_0F00, 32'h0);
        chk_all("lit.nibbles", 1'b0, 3'd5, 3'd2, 32'h00F0_0F00, 32'h0);
        apply(32'h8000_0000, 32'h7FFF_FFFF);
        chk_all("lit.unsigned", 1'b0, 3'd7, 3'd0, 32'h8000_0000, 32'h7FFF_FFFF);
        apply(32'hFFFF_FFFF, 32'h0);
        chk_all("lit.extreme", 1'b0, 3'd7, 3'd0, 32'hFFFF_FFFF, 32'h0);
        apply(32'h0, 32'h0300_0000);
        chk_all("lit.ms_only", 1'b0, 3'd6, 3'd6, 32'h0300_0000, 32'h0);

        // Mid-stream reset pulse between edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("lit.async_rst", 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("lit.recover", 1'b0, 3'd6, 3'd6, 32'h0300_0000, 32'h0);

        // Glitches between edges must not matter; only the value at the edge does.
        @(negedge clk);
        A = 32'hDEAD_BEEF;
        B = 32'h0;
        #2;
        A = 32'h0000_00A0;
        B = 32'h0000_00A0;
        @(posedge clk);
        #1;
        chk_all("lit.glitch", 1'b1, 3'd0, 3'd0, 32'hA0, 32'hA0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (32'hF << (4 * $urandom_range(0, 7)));
                2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            @(negedge clk);
            A = $urandom;
            B = $urandom;
            #1;
            A = ra;
            B = rb;
            if (n % 97 == 50) begin
                #1;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            @(posedge clk);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
